// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared types and helpers for the HUB75 scan driver
//   scan_state_t : scan FSM states
//   HUB_RGB_W    : bits per pixel lane ({b,g,r})
//   max3         : widest of three interval lengths, sizes the shared timer
package led_matrix_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      BLANK,
      LATCH,
      DISPLAY
   } scan_state_t;

   localparam int HUB_RGB_W = 3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/led_matrix_scan_timer.sv
// rtl/led_matrix_scan_timer.sv - loadable down-counter with done flag
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this cycle (has priority over counting)
//   load_val  : value loaded; the interval lasts load_val+1 cycles
//   count     : current remaining count
//   done      : count has reached zero (holds there until reloaded)
module led_matrix_scan_timer
   import led_matrix_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         done
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - HUB75 row scan driver (shift, blank, latch, display)
//   Optional feature macro: LED_SCAN_DIM_EN adds brightness[7:0] (OE duty within DISPLAY).
//   clk, rst        : clock, synchronous active-high reset
//   enable          : run scan, sampled in IDLE and at the end of each row
//   rd_en/rd_col/rd_row : frame-buffer read request, data returns one cycle later
//   rgb_upper/lower : returned {b,g,r} pixels for the upper/lower half
//   frame_sync      : high during the last DISPLAY cycle of the last row
//   hub_rgb1/2, hub_clk, hub_lat, hub_oe_n, hub_addr : panel interface
//   busy            : FSM is not IDLE
module led_matrix_scan
   import led_matrix_pkg::*;
#(
   parameter int COLS      = 64,
   parameter int ROWS_HALF = 16,
   parameter int ADDR_W    = $clog2(ROWS_HALF),
   parameter int CLK_DIV   = 2,
   parameter int BLANK_CYC = 4,
   parameter int ON_TIME   = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
`ifdef LED_SCAN_DIM_EN
   input  logic [7:0]              brightness,
`endif
   output logic                    rd_en,
   output logic [$clog2(COLS)-1:0] rd_col,
   output logic [ADDR_W-1:0]       rd_row,
   input  logic [HUB_RGB_W-1:0]    rgb_upper,
   input  logic [HUB_RGB_W-1:0]    rgb_lower,
   output logic                    frame_sync,
   output logic [HUB_RGB_W-1:0]    hub_rgb1,
   output logic [HUB_RGB_W-1:0]    hub_rgb2,
   output logic                    hub_clk,
   output logic                    hub_lat,
   output logic                    hub_oe_n,
   output logic [ADDR_W-1:0]       hub_addr,
   output logic                    busy
);

   localparam int COL_W = $clog2(COLS);
   localparam int TMR_W = $clog2(max3(2 * CLK_DIV, BLANK_CYC, ON_TIME) + 1);

   // The timer counts down, so a column slot runs count 2*CLK_DIV-1 .. 0.
   localparam logic [TMR_W-1:0] COL_LOAD    = TMR_W'(2 * CLK_DIV - 1);
   localparam logic [TMR_W-1:0] BLANK_LOAD  = TMR_W'(BLANK_CYC - 1);
   localparam logic [TMR_W-1:0] ON_LOAD     = TMR_W'(ON_TIME - 1);
   localparam logic [TMR_W-1:0] CAPTURE_CNT = TMR_W'(2 * CLK_DIV - 2);
   localparam logic [TMR_W-1:0] HIGH_CNT    = TMR_W'(CLK_DIV);

   scan_state_t        state;
   logic [COL_W-1:0]   col;
   logic [ADDR_W-1:0]  row;
   logic [ADDR_W-1:0]  row_nxt;
   logic               last_col;
   logic               last_row;
   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_val;
   logic [TMR_W-1:0]   tmr_count;
   logic               tmr_done;

   assign last_col = (col == COL_W'(COLS - 1));
   assign last_row = (row == ADDR_W'(ROWS_HALF - 1));
   assign row_nxt  = last_row ? '0 : row + 1'b1;

   // OE stays low in DISPLAY while the remaining count is above off_at.
`ifdef LED_SCAN_DIM_EN
   logic [31:0]      on_product;
   logic [TMR_W-1:0] off_at;
   assign on_product = 32'(ON_TIME) * {24'd0, brightness};
`else
   localparam logic [TMR_W-1:0] off_at = '0;
`endif

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = COL_LOAD;
      case (state)
         IDLE:    tmr_load = enable;
         SHIFT: begin
            tmr_load = tmr_done;
            tmr_val  = last_col ? BLANK_LOAD : COL_LOAD;
         end
         LATCH: begin
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
         end
         DISPLAY: tmr_load = tmr_done && enable;
         default: tmr_load = 1'b0;
      endcase
   end

   led_matrix_scan_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .done     (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         row        <= '0;
         col        <= '0;
         rd_en      <= 1'b0;
         rd_col     <= '0;
         rd_row     <= '0;
         hub_rgb1   <= '0;
         hub_rgb2   <= '0;
         hub_clk    <= 1'b0;
         hub_lat    <= 1'b0;
         hub_oe_n   <= 1'b1;
         hub_addr   <= '0;
         frame_sync <= 1'b0;
         busy       <= 1'b0;
`ifdef LED_SCAN_DIM_EN
         off_at     <= '0;
`endif
      end else begin
         rd_en      <= 1'b0;
         hub_lat    <= 1'b0;
         frame_sync <= 1'b0;
         case (state)
            IDLE: begin
               hub_oe_n <= 1'b1;
               hub_clk  <= 1'b0;
               if (enable) begin
                  state  <= SHIFT;
                  busy   <= 1'b1;
                  col    <= '0;
                  rd_en  <= 1'b1;
                  rd_col <= '0;
                  rd_row <= row;
               end
            end
            SHIFT: begin
               // Read data is valid in slot cycle 1; capturing it then puts the
               // pixel on the pins a full cycle before the visible hub_clk rise.
               if (tmr_count == CAPTURE_CNT) begin
                  hub_rgb1 <= rgb_upper;
                  hub_rgb2 <= rgb_lower;
               end
               hub_clk <= (tmr_count < HIGH_CNT);
               if (tmr_done) begin
                  if (last_col) begin
                     state <= BLANK;
                  end else begin
                     col    <= col + 1'b1;
                     rd_en  <= 1'b1;
                     rd_col <= col + 1'b1;
                     rd_row <= row;
                  end
               end
            end
            BLANK: begin
               hub_clk <= 1'b0;
               if (tmr_done) begin
                  state    <= LATCH;
                  hub_lat  <= 1'b1;
                  hub_addr <= row;
               end
            end
            LATCH: begin
               state <= DISPLAY;
`ifdef LED_SCAN_DIM_EN
               off_at   <= TMR_W'(32'(ON_TIME) - (on_product >> 8));
               hub_oe_n <= (on_product[31:8] == 24'd0);
`else
               hub_oe_n <= 1'b0;
`endif
               if (ON_TIME == 1) frame_sync <= last_row;
            end
            DISPLAY: begin
               if (!tmr_done) begin
                  hub_oe_n   <= !(tmr_count > off_at);
                  frame_sync <= (tmr_count == TMR_W'(1)) && last_row;
               end else begin
                  hub_oe_n <= 1'b1;
                  row      <= row_nxt;
                  col      <= '0;
                  if (enable) begin
                     state  <= SHIFT;
                     rd_en  <= 1'b1;
                     rd_col <= '0;
                     rd_row <= row_nxt;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb/tb_led_matrix_scan.sv - directed self-checking bench for led_matrix_scan
module tb_led_matrix_scan;

   localparam int ON      = 8;
   localparam int ROW_CYC = 27;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] brightness;
   logic       rd_en;
   logic [1:0] rd_col;
   logic [0:0] rd_row;
   logic [2:0] rgb_upper = 3'd0;
   logic [2:0] rgb_lower = 3'd0;
   logic       frame_sync;
   logic [2:0] hub_rgb1;
   logic [2:0] hub_rgb2;
   logic       hub_clk;
   logic       hub_lat;
   logic       hub_oe_n;
   logic [0:0] hub_addr;
   logic       busy;

   int checks = 0;
   int errors = 0;

   led_matrix_scan #(
      .COLS(4), .ROWS_HALF(2), .CLK_DIV(2), .BLANK_CYC(2), .ON_TIME(ON)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
`ifdef LED_SCAN_DIM_EN
      .brightness (brightness),
`endif
      .rd_en      (rd_en),
      .rd_col     (rd_col),
      .rd_row     (rd_row),
      .rgb_upper  (rgb_upper),
      .rgb_lower  (rgb_lower),
      .frame_sync (frame_sync),
      .hub_rgb1   (hub_rgb1),
      .hub_rgb2   (hub_rgb2),
      .hub_clk    (hub_clk),
      .hub_lat    (hub_lat),
      .hub_oe_n   (hub_oe_n),
      .hub_addr   (hub_addr),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Frame buffer: one-cycle read latency, pixel value = {row, col}.
   always @(posedge clk) begin
      if (rd_en) begin
         rgb_upper <= {rd_row, rd_col};
         rgb_lower <= ~{rd_row, rd_col};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One scanned row, checked every cycle from its first SHIFT cycle.
   // k: 0..15 SHIFT (4 cycles per column), 16..17 BLANK, 18 LATCH, 19..26 DISPLAY.
   task automatic run_row(input int r, input int bright, input int drop_k, input int rst_k);
      int on_cyc;
      int c;
      int p;
      int pix;
      brightness = 8'(bright);
      on_cyc = ON;
`ifdef LED_SCAN_DIM_EN
      on_cyc = (ON * bright) >> 8;
`endif
      for (int k = 0; k < ROW_CYC; k++) begin
         @(negedge clk);
         c = (k < 16) ? k / 4 : 3;
         p = k % 4;
         pix = r * 4 + c;
         chk("busy", busy, 1);
         chk("rd_en", rd_en, (k < 16 && p == 0));
         if (k < 16 && p == 0) begin
            chk("rd_col", rd_col, c);
            chk("rd_row", rd_row, r);
         end
         chk("hub_clk", hub_clk, (k < 16 && (p == 3 || (p == 0 && k > 0))) || k == 16);
         if ((k < 16 && p >= 2) || k == 16) begin
            chk("hub_rgb1", hub_rgb1, pix);
            chk("hub_rgb2", hub_rgb2, (~pix) & 7);
         end
         chk("hub_lat", hub_lat, (k == 18));
         chk("hub_oe_n", hub_oe_n, !(k >= 19 && k < 19 + on_cyc));
         if (k >= 18) chk("hub_addr", hub_addr, r);
         chk("frame_sync", frame_sync, (k == 26 && r == 1));
         if (k == drop_k) enable = 1'b0;
         if (k == rst_k) begin
            rst = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      brightness = 8'd255;
      repeat (3) @(negedge clk);
      chk("rst_oe_n", hub_oe_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_hub_clk", hub_clk, 0);
      chk("rst_hub_lat", hub_lat, 0);
      chk("rst_hub_addr", hub_addr, 0);
      chk("rst_frame_sync", frame_sync, 0);
      chk("rst_hub_rgb1", hub_rgb1, 0);

      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_oe_n", hub_oe_n, 1);

      // Free run for two frames and a half, then drop enable in SHIFT of row 1.
      enable = 1'b1;
      for (int rr = 0; rr < 6; rr++) begin
         run_row(rr % 2, 255, (rr == 5) ? 5 : -1, -1);
      end

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("stop_busy", busy, 0);
         chk("stop_rd_en", rd_en, 0);
         chk("stop_oe_n", hub_oe_n, 1);
         chk("stop_frame_sync", frame_sync, 0);
      end

      // Restart, then reset in the middle of row 1's DISPLAY.
      enable = 1'b1;
      run_row(0, 128, -1, -1);
      run_row(1, 128, -1, 22);
      @(negedge clk);
      chk("mid_rst_oe_n", hub_oe_n, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_hub_addr", hub_addr, 0);
      chk("mid_rst_rd_en", rd_en, 0);
      chk("mid_rst_hub_lat", hub_lat, 0);
      rst = 1'b0;

      // Scanning restarts at row 0.
      run_row(0, 0, -1, -1);
      run_row(1, 128, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
